// File: rtl/ptp_int_ctl_n_pkg.sv
// ptp_int_ctl_n_pkg
// Shared definitions for the N-source PTP interrupt controller:
//   - register byte offsets relative to the controller base address
//   - interrupt FSM state encoding
//   - a small address-match helper used by the register decode
`timescale 1ns/1ps

package ptp_int_ctl_n_pkg;

    localparam logic [31:0] INT_STATUS_OFS = 32'h00;
    localparam logic [31:0] INT_ENABLE_OFS = 32'h04;
    localparam logic [31:0] INT_MODE_OFS   = 32'h08;
    localparam logic [31:0] INT_PEND_OFS   = 32'h0C;
    localparam logic [31:0] INT_HOLD_OFS   = 32'h10;
    localparam logic [31:0] INT_SET_OFS    = 32'h14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } int_state_t;

    // Full 32-bit equality match; no aliasing of the register window.
    function automatic logic addrHit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] ofs);
        return addr == (base + ofs);
    endfunction

endpackage

// File: rtl/ptp_int_ctl_n_sync.sv
// ptp_int_sync
// Brings NUM_INT interrupt sources onto the bus clock and produces a
// rising-edge vector.
//   i_clk    : bus clock
//   i_rst_n  : synchronous active-low reset
//   i_src    : raw interrupt sources
//   o_sync   : synchronised sources (s)
//   o_rise   : s & ~prev, one cycle per rising edge of s
`timescale 1ns/1ps

module ptp_int_sync #(
    parameter int NUM_INT     = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_INT-1:0] i_src,
    output logic [NUM_INT-1:0] o_sync,
    output logic [NUM_INT-1:0] o_rise
);

    logic [NUM_INT-1:0] w_sync;
    logic [NUM_INT-1:0] r_prev;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_sync = i_src;
        end else begin : g_sync
            logic [NUM_INT-1:0] r_stage [SYNC_STAGES];

            // Plain shift chain; the last stage is the synchronised view.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_src;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign w_sync = r_stage[SYNC_STAGES-1];
        end
    endgenerate

    // prev tracks s every cycle independent of MODE, so switching a bit
    // from level to edge never fabricates an edge. Resetting to 0 means a
    // source already high at reset release yields one edge event.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_sync;
        end
    end

    assign o_sync = w_sync;
    assign o_rise = w_sync & ~r_prev;

endmodule

// File: rtl/ptp_int_ctl_n.sv
// ptp_int_ctl_n
// Parametrised N-source PTP interrupt controller on the bus2ip bus.
// Sources are synchronised, detected per bit as edge or level, latched
// into sticky W1C STATUS, masked by ENABLE and combined into int_ptp_o
// with an optional holdoff (coalescing) period after each service.
//   bus2ip_clk/bus2ip_rst_n : clock, synchronous active-low reset
//   bus2ip_addr_i/data_i    : byte address and write data
//   bus2ip_rd_ce_i/wr_ce_i  : one-cycle read/write strobes
//   ip2bus_data_o           : registered read data, 0 when not addressed
//   int_src_i               : raw interrupt sources
//   int_ptp_o               : combined registered interrupt
`timescale 1ns/1ps

module ptp_int_ctl_n
    import ptp_int_ctl_n_pkg::*;
#(
    parameter logic [31:0] INT_BASE_ADDR = 32'h300,
    parameter int          NUM_INT       = 3,
    parameter int          SYNC_STAGES   = 2,
    parameter int          HOLD_W        = 16,
    parameter logic [31:0] MODE_RST      = 32'h0
) (
    input  logic               bus2ip_clk,
    input  logic               bus2ip_rst_n,
    input  logic [31:0]        bus2ip_addr_i,
    input  logic [31:0]        bus2ip_data_i,
    input  logic               bus2ip_rd_ce_i,
    input  logic               bus2ip_wr_ce_i,
    output logic [31:0]        ip2bus_data_o,
    input  logic [NUM_INT-1:0] int_src_i,
    output logic               int_ptp_o
);

    logic [NUM_INT-1:0] r_status;
    logic [NUM_INT-1:0] r_enable;
    logic [NUM_INT-1:0] r_mode;
    logic [HOLD_W-1:0]  r_holdoff;
    logic [HOLD_W-1:0]  r_cnt;
    int_state_t         r_state;
    logic               r_int;
    logic [31:0]        r_rdata;

    logic [NUM_INT-1:0] w_sync;
    logic [NUM_INT-1:0] w_rise;
    logic [NUM_INT-1:0] w_event;
    logic [NUM_INT-1:0] w_pending;
    logic [NUM_INT-1:0] w_w1c;
    logic [NUM_INT-1:0] w_set;
    logic               w_hit_status;
    logic               w_hit_enable;
    logic               w_hit_mode;
    logic               w_hit_pend;
    logic               w_hit_hold;
    logic               w_hit_set;
    logic [31:0]        w_rd_val;
    logic               w_unused_data;

    ptp_int_sync #(
        .NUM_INT     (NUM_INT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (bus2ip_clk),
        .i_rst_n (bus2ip_rst_n),
        .i_src   (int_src_i),
        .o_sync  (w_sync),
        .o_rise  (w_rise)
    );

    assign w_hit_status = addrHit(bus2ip_addr_i, INT_BASE_ADDR, INT_STATUS_OFS);
    assign w_hit_enable = addrHit(bus2ip_addr_i, INT_BASE_ADDR, INT_ENABLE_OFS);
    assign w_hit_mode   = addrHit(bus2ip_addr_i, INT_BASE_ADDR, INT_MODE_OFS);
    assign w_hit_pend   = addrHit(bus2ip_addr_i, INT_BASE_ADDR, INT_PEND_OFS);
    assign w_hit_hold   = addrHit(bus2ip_addr_i, INT_BASE_ADDR, INT_HOLD_OFS);
    assign w_hit_set    = addrHit(bus2ip_addr_i, INT_BASE_ADDR, INT_SET_OFS);

    assign w_w1c = (bus2ip_wr_ce_i && w_hit_status) ? bus2ip_data_i[NUM_INT-1:0] : '0;
    assign w_set = (bus2ip_wr_ce_i && w_hit_set)    ? bus2ip_data_i[NUM_INT-1:0] : '0;

    // Data bits above NUM_INT/HOLD_W are intentionally ignored.
    assign w_unused_data = ^bus2ip_data_i;

    assign w_event   = (r_mode & w_rise) | (~r_mode & w_sync);
    assign w_pending = r_status & r_enable;

    // Clear is applied first, so a concurrent event or software set wins;
    // a level source that is still high therefore re-sets its bit.
    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_w1c) | w_event | w_set;
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            r_enable  <= '0;
            r_mode    <= MODE_RST[NUM_INT-1:0];
            r_holdoff <= '0;
        end else if (bus2ip_wr_ce_i) begin
            if (w_hit_enable) begin
                r_enable <= bus2ip_data_i[NUM_INT-1:0];
            end
            if (w_hit_mode) begin
                r_mode <= bus2ip_data_i[NUM_INT-1:0];
            end
            if (w_hit_hold) begin
                r_holdoff <= bus2ip_data_i[HOLD_W-1:0];
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        if (w_hit_status) begin
            w_rd_val = 32'(r_status);
        end else if (w_hit_enable) begin
            w_rd_val = 32'(r_enable);
        end else if (w_hit_mode) begin
            w_rd_val = 32'(r_mode);
        end else if (w_hit_pend) begin
            w_rd_val = 32'(w_pending);
        end else if (w_hit_hold) begin
            w_rd_val = 32'(r_holdoff);
        end
    end

    // Read data is zero whenever no read strobe is present so it can be
    // ORed with the other slaves' read data.
    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= bus2ip_rd_ce_i ? w_rd_val : '0;
        end
    end

    // Interrupt FSM. After the pending set empties, the output stays low
    // for HOLDOFF cycles before new pending bits can re-raise it; the
    // count is captured on entry to HOLD so HOLDOFF writes during a hold
    // only affect the next one.
    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_int   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending) begin
                        r_state <= ST_ASSERT;
                        r_int   <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (w_pending == '0) begin
                        r_int <= 1'b0;
                        if (r_holdoff == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_holdoff;
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    r_cnt <= r_cnt - HOLD_W'(1);
                    if (r_cnt == HOLD_W'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_int   <= 1'b0;
                end
            endcase
        end
    end

    assign ip2bus_data_o = r_rdata;
    assign int_ptp_o     = r_int;

endmodule

// File: tb/tb_ptp_int_ctl_n.sv
// tb_ptp_int_ctl_n
// Self-checking bench for ptp_int_ctl_n. A default 3-source instance
// (MODE_RST = 3'b101) covers register access and interrupt behaviour; a
// 32-source, 32-bit holdoff instance covers reset in the middle of HOLD.
// Both share the bus; each has its own reset, sources and outputs.
`timescale 1ns/1ps

module tb_ptp_int_ctl_n;

    localparam logic [31:0] BASE = 32'h300;

    typedef struct {
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    logic        clk;
    logic        rstN;
    logic        rst32N;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdCe;
    logic        wrCe;
    logic [2:0]  src;
    logic [31:0] src32;
    logic [31:0] rdata;
    logic [31:0] rdata32;
    logic        intOut;
    logic        int32;

    int          checks;
    int          passes;
    logic [31:0] expQ[$];

    ptp_int_ctl_n #(
        .INT_BASE_ADDR (BASE),
        .NUM_INT       (3),
        .SYNC_STAGES   (2),
        .HOLD_W        (16),
        .MODE_RST      (32'h5)
    ) dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst_n   (rstN),
        .bus2ip_addr_i  (addr),
        .bus2ip_data_i  (wdata),
        .bus2ip_rd_ce_i (rdCe),
        .bus2ip_wr_ce_i (wrCe),
        .ip2bus_data_o  (rdata),
        .int_src_i      (src),
        .int_ptp_o      (intOut)
    );

    ptp_int_ctl_n #(
        .INT_BASE_ADDR (BASE),
        .NUM_INT       (32),
        .SYNC_STAGES   (2),
        .HOLD_W        (32),
        .MODE_RST      (32'h0)
    ) dut32 (
        .bus2ip_clk     (clk),
        .bus2ip_rst_n   (rst32N),
        .bus2ip_addr_i  (addr),
        .bus2ip_data_i  (wdata),
        .bus2ip_rd_ce_i (rdCe),
        .bus2ip_wr_ce_i (wrCe),
        .ip2bus_data_o  (rdata32),
        .int_src_i      (src32),
        .int_ptp_o      (int32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wrCe  = 1'b1;
        tick(1);
        wrCe  = 1'b0;
        wdata = '0;
    endtask

    // Expected value goes into the scoreboard when the strobe is driven
    // and is popped when the registered read data appears.
    task automatic busRead(input logic [31:0] a, input logic [31:0] expected,
                           input bit use32, input string name);
        logic [31:0] exp;
        addr = a;
        rdCe = 1'b1;
        expQ.push_back(expected);
        tick(1);
        rdCe = 1'b0;
        exp  = expQ.pop_front();
        checkOutput(name, use32 ? rdata32 : rdata, exp);
    endtask

    task automatic applyStimulus(input vec_t vecs[$]);
        foreach (vecs[i]) begin
            if (vecs[i].isWrite) begin
                busWrite(vecs[i].addr, vecs[i].data);
            end else begin
                busRead(vecs[i].addr, vecs[i].data, 1'b0, $sformatf("vec%0d", i));
            end
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   lowCycles;
        bit   rose;

        checks = 0;
        passes = 0;
        rstN   = 1'b0;
        rst32N = 1'b0;
        addr   = '0;
        wdata  = '0;
        rdCe   = 1'b0;
        wrCe   = 1'b0;
        src    = '0;
        src32  = '0;

        tick(3);
        rstN   = 1'b1;
        rst32N = 1'b1;
        tick(1);

        // Reset state.
        checkOutput("rstInt", 32'(intOut), 32'h0);
        checkOutput("rstRdataIdle", rdata, 32'h0);
        busRead(BASE + 32'h00, 32'h0, 1'b0, "rstStatus");
        busRead(BASE + 32'h04, 32'h0, 1'b0, "rstEnable");
        busRead(BASE + 32'h08, 32'h5, 1'b0, "rstMode");
        busRead(BASE + 32'h0C, 32'h0, 1'b0, "rstPending");
        busRead(BASE + 32'h10, 32'h0, 1'b0, "rstHoldoff");

        // Register access table; reads carry their expected value.
        vecs.push_back('{1'b1, BASE + 32'h04, 32'hFFFF_FFFF});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0000_0007});
        vecs.push_back('{1'b0, 32'h1000_0304, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h1000_0304, 32'h0000_0000});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0000_0007});
        vecs.push_back('{1'b0, BASE + 32'h0C, 32'h0000_0000});
        vecs.push_back('{1'b1, BASE + 32'h08, 32'h0000_0002});
        vecs.push_back('{1'b0, BASE + 32'h08, 32'h0000_0002});
        vecs.push_back('{1'b1, BASE + 32'h10, 32'h0001_2345});
        vecs.push_back('{1'b0, BASE + 32'h10, 32'h0000_2345});
        vecs.push_back('{1'b1, BASE + 32'h0C, 32'h0000_0007});
        vecs.push_back('{1'b0, BASE + 32'h0C, 32'h0000_0000});
        vecs.push_back('{1'b0, BASE + 32'h14, 32'h0000_0000});
        vecs.push_back('{1'b0, BASE + 32'h18, 32'h0000_0000});
        vecs.push_back('{1'b1, BASE + 32'h04, 32'h0000_0000});
        vecs.push_back('{1'b0, BASE + 32'h04, 32'h0000_0000});
        vecs.push_back('{1'b1, BASE + 32'h10, 32'h0000_0000});
        vecs.push_back('{1'b0, BASE + 32'h10, 32'h0000_0000});
        applyStimulus(vecs);

        // Edge mode: one-cycle pulse reaches STATUS after 3 edges, the
        // interrupt one edge later.
        busWrite(BASE + 32'h08, 32'h7);
        busWrite(BASE + 32'h04, 32'h1);
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(2);
        checkOutput("edgeIntNotYet", 32'(intOut), 32'h0);
        tick(1);
        checkOutput("edgeIntRise", 32'(intOut), 32'h1);
        busRead(BASE + 32'h00, 32'h1, 1'b0, "edgeStatus");
        busWrite(BASE + 32'h00, 32'h1);
        tick(1);
        checkOutput("edgeIntCleared", 32'(intOut), 32'h0);
        busRead(BASE + 32'h00, 32'h0, 1'b0, "edgeStatusCleared");

        // Level mode on bit 1: cannot be cleared while the source is high.
        busWrite(BASE + 32'h08, 32'h5);
        src[1] = 1'b1;
        tick(4);
        busWrite(BASE + 32'h00, 32'h2);
        busRead(BASE + 32'h00, 32'h2, 1'b0, "levelStuck");
        src[1] = 1'b0;
        tick(3);
        busWrite(BASE + 32'h00, 32'h2);
        busRead(BASE + 32'h00, 32'h0, 1'b0, "levelCleared");

        // Holdoff of 10: second event arrives during HOLD. Output stays low
        // through 10 HOLD cycles plus the IDLE cycle, so 11 low samples.
        busWrite(BASE + 32'h10, 32'd10);
        src[0] = 1'b1;
        tick(1);
        src[0] = 1'b0;
        tick(3);
        checkOutput("holdFirstRise", 32'(intOut), 32'h1);
        busWrite(BASE + 32'h00, 32'h1);
        lowCycles = 0;
        rose      = 1'b0;
        tick(1);
        if (!intOut) lowCycles++;
        src[0] = 1'b1;
        tick(1);
        if (!intOut) lowCycles++;
        src[0] = 1'b0;
        tick(1);
        if (!intOut) lowCycles++;
        tick(1);
        if (!intOut) lowCycles++;
        busRead(BASE + 32'h00, 32'h1, 1'b0, "holdStatusAtOnce");
        if (!intOut) lowCycles++;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (intOut) begin
                rose = 1'b1;
                break;
            end
            lowCycles++;
        end
        checkOutput("holdRose", 32'(rose), 32'h1);
        checkOutput("holdLowCycles", 32'(lowCycles), 32'd11);
        busWrite(BASE + 32'h10, 32'h0);
        busWrite(BASE + 32'h00, 32'h1);
        tick(2);
        checkOutput("holdDone", 32'(intOut), 32'h0);

        // Software set and set-beats-clear on bit 2 (edge mode, masked).
        busWrite(BASE + 32'h14, 32'h4);
        busRead(BASE + 32'h00, 32'h4, 1'b0, "swSet");
        busWrite(BASE + 32'h00, 32'h4);
        busRead(BASE + 32'h00, 32'h0, 1'b0, "swSetCleared");
        src[2] = 1'b1;
        tick(1);
        src[2] = 1'b0;
        tick(1);
        busWrite(BASE + 32'h00, 32'h4);
        busRead(BASE + 32'h00, 32'h4, 1'b0, "setBeatsClear");
        busRead(BASE + 32'h14, 32'h0, 1'b0, "setReadsZero");
        busRead(BASE + 32'h18, 32'h0, 1'b0, "unmappedZero");

        // PENDING view and the interrupt it drives.
        busWrite(BASE + 32'h04, 32'h6);
        busRead(BASE + 32'h0C, 32'h4, 1'b0, "pending");
        checkOutput("pendingInt", 32'(intOut), 32'h1);
        busWrite(BASE + 32'h00, 32'h4);
        tick(1);
        checkOutput("pendingIntCleared", 32'(intOut), 32'h0);

        // Clearing ENABLE while asserted drops the output; STATUS persists.
        busWrite(BASE + 32'h04, 32'h1);
        busWrite(BASE + 32'h14, 32'h1);
        tick(1);
        checkOutput("enaIntRise", 32'(intOut), 32'h1);
        busWrite(BASE + 32'h04, 32'h0);
        tick(1);
        checkOutput("enaIntDrop", 32'(intOut), 32'h0);
        busRead(BASE + 32'h00, 32'h1, 1'b0, "enaStatusKept");
        busWrite(BASE + 32'h00, 32'h1);

        // 32-source instance: reset in the middle of a 100-cycle HOLD.
        rst32N = 1'b0;
        tick(2);
        rst32N = 1'b1;
        busWrite(BASE + 32'h10, 32'd100);
        busWrite(BASE + 32'h04, 32'h8000_0001);
        busWrite(BASE + 32'h14, 32'h8000_0000);
        tick(1);
        checkOutput("w32IntRise", 32'(int32), 32'h1);
        busWrite(BASE + 32'h00, 32'h8000_0000);
        tick(2);
        checkOutput("w32InHold", 32'(int32), 32'h0);
        busWrite(BASE + 32'h14, 32'h1);
        tick(3);
        busRead(BASE + 32'h00, 32'h1, 1'b1, "w32StatusInHold");
        rst32N = 1'b0;
        tick(1);
        rst32N = 1'b1;
        checkOutput("w32RstInt", 32'(int32), 32'h0);
        busRead(BASE + 32'h00, 32'h0, 1'b1, "w32RstStatus");
        busRead(BASE + 32'h10, 32'h0, 1'b1, "w32RstHoldoff");
        busWrite(BASE + 32'h04, 32'h1);
        busWrite(BASE + 32'h14, 32'h1);
        tick(1);
        checkOutput("w32IdleAfterRst", 32'(int32), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
